// File: rtl/bcd_serial_add_ctrl_pkg.sv
// Shared BCD definitions: digit width, largest legal digit and controller states.
package bcd_pkg;
  localparam int DIGIT_W = 4;
  localparam logic [DIGIT_W-1:0] BCD_MAX = 4'd9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } bcd_ctrl_state_t;
endpackage

// File: rtl/bcd_serial_add_ctrl_if.sv
// Requester-side bundle: start/operands in, busy/done/result out.
// The master modport is the requester and the slave modport is the controller.
interface bcd_serial_add_ctrl_if #(
  parameter int DIGITS = 4
);
  logic                              start;
  logic [bcd_pkg::DIGIT_W*DIGITS-1:0] x;
  logic [bcd_pkg::DIGIT_W*DIGITS-1:0] y;
  logic                              cin;
  logic                              busy;
  logic                              done;
  logic [bcd_pkg::DIGIT_W*DIGITS-1:0] sum;
  logic                              cout;
  logic                              error;

  modport master (output start, x, y, cin, input busy, done, sum, cout, error);
  modport slave  (input start, x, y, cin, output busy, done, sum, cout, error);
endinterface

// File: rtl/bcd_serial_add_ctrl_adder.sv
// Combinational single-digit BCD adder; result holds the two-digit BCD sum.
// An out-of-range operand digit forces a zero result and no carry.
module bcd_adder
  import bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] X,
  input  logic [DIGIT_W-1:0] Y,
  input  logic               c_in,
  output logic               c_out,
  output logic [7:0]         result,
  output logic               out_of_range
);
  logic [4:0] bin;

  always_comb begin
    out_of_range = (X > BCD_MAX) || (Y > BCD_MAX);
    bin          = {1'b0, X} + {1'b0, Y} + {4'b0, c_in};
    result       = '0;
    c_out        = 1'b0;
    if (!out_of_range) begin
      if (bin > 5'd9) begin
        c_out  = 1'b1;
        result = {4'd1, 4'(bin - 5'd10)};
      end else begin
        result = {4'd0, bin[3:0]};
      end
    end
  end
endmodule

// File: rtl/bcd_serial_add_ctrl.sv
// Digit-serial packed-BCD adder controller, LSD first, one digit per clock.
// done pulses DIGITS edges after start is accepted; start is ignored while busy.
module bcd_serial_add_ctrl
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  bcd_serial_add_ctrl_if.slave  bus
);
  localparam int W  = DIGIT_W * DIGITS;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IW-1:0] LAST = IW'(DIGITS - 1);

  bcd_ctrl_state_t state, state_nxt;
  logic            load, step, last;

  logic [W-1:0]    x_q, y_q, acc_q, acc_nxt, sum_q;
  logic [IW-1:0]   idx_q;
  logic            carry_q, carry_nxt, err_q, err_nxt;
  logic            cout_q, error_q;

  logic [DIGIT_W-1:0] xd, yd, dig;
  logic [7:0]         a_res;
  logic               a_cout, a_oor;

  assign xd = x_q[idx_q*DIGIT_W +: DIGIT_W];
  assign yd = y_q[idx_q*DIGIT_W +: DIGIT_W];

  bcd_adder u_adder (
    .X            (xd),
    .Y            (yd),
    .c_in         (carry_q),
    .c_out        (a_cout),
    .result       (a_res),
    .out_of_range (a_oor)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          load      = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (idx_q == LAST) state_nxt = DONE;
      end
      DONE: begin
        if (bus.start) begin
          load      = 1'b1;
          state_nxt = RUN;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign last = step && (idx_q == LAST);

  // A bad digit contributes a zero and breaks the carry chain.
  always_comb begin
    dig       = a_oor ? '0 : a_res[DIGIT_W-1:0];
    carry_nxt = a_oor ? 1'b0 : a_cout;
    err_nxt   = err_q | a_oor;
    acc_nxt   = acc_q;
    acc_nxt[idx_q*DIGIT_W +: DIGIT_W] = dig;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      x_q     <= '0;
      y_q     <= '0;
      acc_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      err_q   <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      if (load) begin
        x_q     <= bus.x;
        y_q     <= bus.y;
        carry_q <= bus.cin;
        idx_q   <= '0;
        acc_q   <= '0;
        err_q   <= 1'b0;
      end
      if (step) begin
        acc_q   <= acc_nxt;
        carry_q <= carry_nxt;
        err_q   <= err_nxt;
        idx_q   <= idx_q + 1'b1;
      end
      if (last) begin
        sum_q   <= acc_nxt;
        cout_q  <= carry_nxt;
        error_q <= err_nxt;
      end
    end
  end

  assign bus.busy  = (state == RUN);
  assign bus.done  = (state == DONE);
  assign bus.sum   = sum_q;
  assign bus.cout  = cout_q;
  assign bus.error = error_q;
endmodule
